shift_register_universal: RTL and testbench
===========================================

Name: shift_register_universal

Overview:
- Parametrised successor to the team's fixed 4-bit right-shift register.
- Adds WIDTH-generic storage, a mode select (shift right/left, arithmetic shift, rotate, parallel load, clear), serial outputs at both ends, and a shift counter with word-complete flag and pulse.
- Used as a serialiser/deserialiser and general-purpose data-path register in lab designs.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..32.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into q on reset.
- CNT_W, $clog2(WIDTH+1), width of the count output; derived, never overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  when 0, all state holds regardless of mode.
- mode  input  3  operation select (encoding below).
- din_r  input  1  serial input for SHR; enters at the MSB.
- din_l  input  1  serial input for SHL; enters at the LSB.
- pdin  input  WIDTH  parallel data for LOAD.
- q  output  WIDTH  register contents.
- sout_r  output  1  equals q[0], combinational.
- sout_l  output  1  equals q[WIDTH-1], combinational.
- count  output  CNT_W  serial shifts since last LOAD/CLEAR/reset; saturates at WIDTH.
- full  output  1  high when count == WIDTH, combinational from count.
- word_done  output  1  one-cycle registered pulse on the edge where count goes from WIDTH-1 to WIDTH.

Behaviour:
- Reset (rst=0, asynchronous, any time including mid-operation): q=RESET_VALUE, count=0, word_done=0. Operation resumes on the first rising edge after rst returns to 1.
- enable=0: q and count hold; word_done=0 on that edge.
- With enable=1, mode selects the operation at each edge:
  - 000 HOLD: q holds, count holds.
  - 001 SHR: q <= {din_r, q[WIDTH-1:1]}; count +1.
  - 010 SHL: q <= {q[WIDTH-2:0], din_l}; count +1.
  - 011 LOAD: q <= pdin; count <= 0.
  - 100 ROTR: q <= {q[0], q[WIDTH-1:1]}; count holds.
  - 101 ROTL: q <= {q[WIDTH-2:0], q[WIDTH-1]}; count holds.
  - 110 ASR: q <= {q[WIDTH-1], q[WIDTH-1:1]}; din_r ignored; count +1.
  - 111 CLEAR: q <= 0; count <= 0.
- Count:
  - Saturates at WIDTH: further shifts leave it at WIDTH and full stays high.
  - No wrap-around.
  - Only LOAD, CLEAR or reset lower it.
- word_done:
  - Registered; high for exactly the one cycle following the edge where count becomes WIDTH.
  - Not reasserted while saturated.
  - Reasserts only after count has been lowered and climbs back to WIDTH.
- Latency: q, count and word_done update one edge after inputs are sampled. sout_r, sout_l and full follow q/count combinationally.
- Illegal X on mode with enable=1 is not required to be handled; all 8 encodings are legal.

Optional Feature:
- Macro: SHIFT_REG_PARITY_EN.
- Defined: adds output parity (1 bit), a registered even parity of q, i.e. ^q of the value being written. It updates on the same edge as q, resets to ^RESET_VALUE, and holds when enable=0.
- Not defined: no parity port and no parity logic; all other behaviour is identical.

Test Plan:
- WIDTH=4, reset then SHR with din_r=1,0,1,1 over 4 edges -> q=1000,0100,1010,1101; count=1..4; full=1 and word_done=1 for exactly one cycle after the 4th edge.
- LOAD pdin=1001, then ROTR twice -> q=1100 then 0110; count=0 throughout; sout_r=0 and sout_l=0 at end.
- LOAD 1000, then ASR three times -> q=1100,1110,1111; count=3; din_r toggled with no effect.
- LOAD 0001, then SHL with din_l=0 five times -> q ends 0000; count saturates at 4; word_done pulses once only; full stays 1.
- After a shift, apply SHR with enable=0 for 3 cycles -> q and count unchanged; word_done=0.
- Mid-SHR sequence (count=2), assert rst=0 between edges -> q=RESET_VALUE and count=0 immediately without a clock edge. With SHIFT_REG_PARITY_EN defined, LOAD 0111 -> parity=1.

Source files
------------

// File: rtl/shift_register_universal.sv
// Universal shift register, WIDTH bits wide. It supports hold, logical shift
// right and left, parallel load, rotate right and left, arithmetic shift right
// and clear. The shift counter saturates at WIDTH and raises a one-cycle
// word_done pulse when the word completes.
// Optional feature: define SHIFT_REG_PARITY_EN to add a registered even-parity
// output (parity_o) that tracks q.
module shift_register_universal #(
   parameter int unsigned        WIDTH       = 8,
   parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
   localparam int unsigned       CNT_W       = $clog2(WIDTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             enable_i,
   input  logic [2:0]       mode_i,
   input  logic             din_r_i,
   input  logic             din_l_i,
   input  logic [WIDTH-1:0] pdin_i,
   output logic [WIDTH-1:0] q_o,
   output logic             sout_r_o,
   output logic             sout_l_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             word_done_o
`ifdef SHIFT_REG_PARITY_EN
   ,
   output logic             parity_o
`endif
);

   typedef enum logic [2:0] {
      ModeHold  = 3'b000,
      ModeShr   = 3'b001,
      ModeShl   = 3'b010,
      ModeLoad  = 3'b011,
      ModeRotr  = 3'b100,
      ModeRotl  = 3'b101,
      ModeAsr   = 3'b110,
      ModeClear = 3'b111
   } mode_e;

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(WIDTH);

   logic [WIDTH-1:0] q_q, q_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             word_done_q, word_done_d;
   logic             cnt_inc;
   logic             cnt_clr;

   // Decode the mode into the next register value and the counter action.
   always_comb begin
      q_d     = q_q;
      cnt_inc = 1'b0;
      cnt_clr = 1'b0;
      if (enable_i) begin
         unique case (mode_e'(mode_i))
            ModeHold:  q_d = q_q;
            ModeShr: begin
               q_d     = {din_r_i, q_q[WIDTH-1:1]};
               cnt_inc = 1'b1;
            end
            ModeShl: begin
               q_d     = {q_q[WIDTH-2:0], din_l_i};
               cnt_inc = 1'b1;
            end
            ModeLoad: begin
               q_d     = pdin_i;
               cnt_clr = 1'b1;
            end
            ModeRotr:  q_d = {q_q[0], q_q[WIDTH-1:1]};
            ModeRotl:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            ModeAsr: begin
               q_d     = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
               cnt_inc = 1'b1;
            end
            ModeClear: begin
               q_d     = '0;
               cnt_clr = 1'b1;
            end
            default:   q_d = q_q;
         endcase
      end
   end

   // Saturating shift counter; word_done fires only on the WIDTH-1 -> WIDTH step.
   always_comb begin
      count_d     = count_q;
      word_done_d = 1'b0;
      if (cnt_clr) begin
         count_d = '0;
      end else if (cnt_inc && (count_q != CntMax)) begin
         count_d     = count_q + CNT_W'(1);
         word_done_d = (count_q == CntMax - CNT_W'(1));
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_q         <= RESET_VALUE;
         count_q     <= '0;
         word_done_q <= 1'b0;
      end else begin
         q_q         <= q_d;
         count_q     <= count_d;
         word_done_q <= word_done_d;
      end
   end

`ifdef SHIFT_REG_PARITY_EN
   logic parity_q;

   // Parity of the value being written; q_d equals q_q while disabled, so it holds.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         parity_q <= ^RESET_VALUE;
      end else begin
         parity_q <= ^q_d;
      end
   end

   assign parity_o = parity_q;
`endif

   assign q_o         = q_q;
   assign sout_r_o    = q_q[0];
   assign sout_l_o    = q_q[WIDTH-1];
   assign count_o     = count_q;
   assign full_o      = (count_q == CntMax);
   assign word_done_o = word_done_q;

endmodule

// File: tb/tb_shift_register_universal.sv
// Self-checking bench for shift_register_universal at WIDTH=4. It runs directed
// steps followed by random traffic. A behavioural model tracks the expected
// register value, count and pulse, and the bench compares the DUT against it
// after every edge.
module tb_shift_register_universal;

   localparam int unsigned W    = 4;
   localparam int unsigned CW   = 3;
   localparam int unsigned MASK = (1 << W) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic [2:0]    mode;
   logic          din_r;
   logic          din_l;
   logic [W-1:0]  pdin;
   logic [W-1:0]  q;
   logic          sout_r;
   logic          sout_l;
   logic [CW-1:0] count;
   logic          full;
   logic          word_done;
`ifdef SHIFT_REG_PARITY_EN
   logic          parity;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int unsigned m_q;
   int unsigned m_cnt;
   logic        m_wd;

   int wd_hits;

   shift_register_universal #(
      .WIDTH       (W),
      .RESET_VALUE (4'b0000)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .enable_i    (enable),
      .mode_i      (mode),
      .din_r_i     (din_r),
      .din_l_i     (din_l),
      .pdin_i      (pdin),
      .q_o         (q),
      .sout_r_o    (sout_r),
      .sout_l_o    (sout_l),
      .count_o     (count),
      .full_o      (full),
      .word_done_o (word_done)
`ifdef SHIFT_REG_PARITY_EN
      ,
      .parity_o    (parity)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q   = 0;
      m_cnt = 0;
      m_wd  = 1'b0;
   endtask

   // Expected behaviour written as plain arithmetic on integers
   task automatic model_edge(input logic en, input logic [2:0] md, input logic dr,
                             input logic dl, input logic [W-1:0] pd);
      int unsigned prev;
      logic        shifted;
      prev    = m_cnt;
      shifted = 1'b0;
      m_wd    = 1'b0;
      if (en) begin
         case (md)
            3'd1: begin m_q = (m_q >> 1) | (int'(dr) << (W - 1)); shifted = 1'b1; end
            3'd2: begin m_q = ((m_q << 1) | int'(dl)) & MASK; shifted = 1'b1; end
            3'd3: begin m_q = int'(pd); m_cnt = 0; end
            3'd4: m_q = (m_q >> 1) | ((m_q & 1) << (W - 1));
            3'd5: m_q = ((m_q << 1) | (m_q >> (W - 1))) & MASK;
            3'd6: begin m_q = (m_q >> 1) | (m_q & (1 << (W - 1))); shifted = 1'b1; end
            3'd7: begin m_q = 0; m_cnt = 0; end
            default: ;
         endcase
         if (shifted && m_cnt < W) m_cnt = m_cnt + 1;
         m_wd = (prev == W - 1) && (m_cnt == W);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".q"}, 32'(q), m_q);
      check({tag, ".count"}, 32'(count), m_cnt);
      check({tag, ".full"}, 32'(full), 32'(m_cnt == W));
      check({tag, ".word_done"}, 32'(word_done), 32'(m_wd));
      check({tag, ".sout_r"}, 32'(sout_r), m_q & 1);
      check({tag, ".sout_l"}, 32'(sout_l), (m_q >> (W - 1)) & 1);
`ifdef SHIFT_REG_PARITY_EN
      check({tag, ".parity"}, 32'(parity), 32'($countones(m_q) % 2));
`endif
   endtask

   // Drive inputs, take one rising edge, then compare 1 time unit later
   task automatic cycle(input string tag, input logic en, input logic [2:0] md,
                        input logic dr, input logic dl, input logic [W-1:0] pd);
      enable = en;
      mode   = md;
      din_r  = dr;
      din_l  = dl;
      pdin   = pd;
      @(posedge clk);
      model_edge(en, md, dr, dl, pd);
      #1;
      check_all(tag);
      if (word_done === 1'b1) wd_hits++;
   endtask

   initial begin
      rst_n  = 1'b0;
      enable = 1'b0;
      mode   = 3'd0;
      din_r  = 1'b0;
      din_l  = 1'b0;
      pdin   = '0;
      model_reset();
      #12;
      check_all("reset");
      rst_n = 1'b1;
      #1;
      check_all("reset_release");

      // Serial-in right: 1,0,1,1
      cycle("shr1", 1'b1, 3'd1, 1'b1, 1'b0, 4'h0);
      check("plan_shr1_q", 32'(q), 32'h8);
      cycle("shr2", 1'b1, 3'd1, 1'b0, 1'b0, 4'h0);
      check("plan_shr2_q", 32'(q), 32'h4);
      cycle("shr3", 1'b1, 3'd1, 1'b1, 1'b0, 4'h0);
      check("plan_shr3_q", 32'(q), 32'hA);
      cycle("shr4", 1'b1, 3'd1, 1'b1, 1'b0, 4'h0);
      check("plan_shr4_q", 32'(q), 32'hD);
      check("plan_shr4_count", 32'(count), 32'd4);
      check("plan_shr4_full", 32'(full), 32'd1);
      check("plan_shr4_wd", 32'(word_done), 32'd1);
      cycle("hold_after_word", 1'b1, 3'd0, 1'b0, 1'b0, 4'h0);
      check("plan_wd_one_cycle", 32'(word_done), 32'd0);

      // Load then rotate right twice
      cycle("load9", 1'b1, 3'd3, 1'b0, 1'b0, 4'h9);
      cycle("rotr1", 1'b1, 3'd4, 1'b1, 1'b1, 4'h0);
      check("plan_rotr1_q", 32'(q), 32'hC);
      cycle("rotr2", 1'b1, 3'd4, 1'b1, 1'b1, 4'h0);
      check("plan_rotr2_q", 32'(q), 32'h6);
      check("plan_rotr_count", 32'(count), 32'd0);
      check("plan_rotr_souts", 32'({sout_r, sout_l}), 32'd0);

      // Arithmetic shift; din_r must be ignored
      cycle("load8", 1'b1, 3'd3, 1'b0, 1'b0, 4'h8);
      cycle("asr1", 1'b1, 3'd6, 1'b0, 1'b0, 4'h0);
      cycle("asr2", 1'b1, 3'd6, 1'b1, 1'b0, 4'h0);
      cycle("asr3", 1'b1, 3'd6, 1'b0, 1'b0, 4'h0);
      check("plan_asr_q", 32'(q), 32'hF);
      check("plan_asr_count", 32'(count), 32'd3);

      // Shift left past saturation
      cycle("load1", 1'b1, 3'd3, 1'b0, 1'b0, 4'h1);
      wd_hits = 0;
      for (int i = 0; i < 5; i++) cycle("shl_sat", 1'b1, 3'd2, 1'b1, 1'b0, 4'h0);
      check("plan_shl_q", 32'(q), 32'h0);
      check("plan_shl_count", 32'(count), 32'd4);
      check("plan_shl_full", 32'(full), 32'd1);
      check("plan_shl_wd_once", 32'(wd_hits), 32'd1);

      // Disabled cycles hold everything
      cycle("clear", 1'b1, 3'd7, 1'b0, 1'b0, 4'h0);
      cycle("shr_one", 1'b1, 3'd1, 1'b1, 1'b0, 4'h0);
      for (int i = 0; i < 3; i++) cycle("disabled", 1'b0, 3'd1, 1'b0, 1'b1, 4'h5);
      check("plan_dis_q", 32'(q), 32'h8);
      check("plan_dis_count", 32'(count), 32'd1);

      // Asynchronous reset between edges
      cycle("load_f", 1'b1, 3'd3, 1'b0, 1'b0, 4'hF);
      cycle("pre_rst1", 1'b1, 3'd1, 1'b0, 1'b0, 4'h0);
      cycle("pre_rst2", 1'b1, 3'd1, 1'b0, 1'b0, 4'h0);
      check("plan_prerst_count", 32'(count), 32'd2);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("async_rst");
      check("plan_async_q", 32'(q), 32'h0);
      #2;
      rst_n = 1'b1;
      #1;
      check_all("async_rst_release");

`ifdef SHIFT_REG_PARITY_EN
      cycle("load7", 1'b1, 3'd3, 1'b0, 1'b0, 4'h7);
      check("plan_parity", 32'(parity), 32'd1);
`endif

      // Random traffic; loads and clears are kept rare so the count saturates often
      for (int i = 0; i < 400; i++) begin
         logic [2:0] md;
         md = 3'($urandom_range(0, 7));
         if ((md == 3'd3 || md == 3'd7) && ($urandom_range(0, 3) != 0)) md = 3'd1;
         cycle("rand", ($urandom_range(0, 7) != 0), md, 1'($urandom),
               1'($urandom), 4'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
